// File: rtl/coin_vend_ctrl.sv
// rtl/coin_vend_ctrl.sv - two-denomination coin vending controller with change handshake
module coin_vend_ctrl #(
    parameter int CREDIT_W   = 4,
    parameter int PRICE      = 3,
    parameter int COIN_A_VAL = 1,
    parameter int COIN_B_VAL = 2,
    parameter int MAX_CREDIT = 4,
    parameter int CNT_W      = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic                coin_sel,
    input  logic                cancel,
    output logic                coin_ready,
    output logic                coin_reject,
    output logic                dispense,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    input  logic                change_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic [CNT_W-1:0]    vend_count
);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_VEND    = 2'd1;
    localparam logic [1:0] ST_CHANGE  = 2'd2;

    localparam logic [CREDIT_W:0]   VAL_A     = (CREDIT_W+1)'(COIN_A_VAL);
    localparam logic [CREDIT_W:0]   VAL_B     = (CREDIT_W+1)'(COIN_B_VAL);
    localparam logic [CREDIT_W:0]   MAX_W     = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W:0]   PRICE_W   = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);

    logic [1:0]          state;
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   sum;
    logic [CREDIT_W:0]   eff_credit;
    logic [CREDIT_W-1:0] remainder;
    logic                coin_seen;
    logic                coin_bad;
    logic                coin_take;

    assign coin_ready   = (state == ST_COLLECT);
    assign dispense     = (state == ST_VEND);
    assign change_valid = (state == ST_CHANGE);

    // Sum is one bit wider so an over-credit coin cannot wrap past the limit check.
    always_comb begin
        coin_val   = coin_sel ? VAL_B : VAL_A;
        sum        = {1'b0, credit} + coin_val;
        coin_seen  = (state == ST_COLLECT) && coin_valid;
        coin_bad   = coin_seen && (sum > MAX_W);
        coin_take  = coin_seen && !coin_bad;
        eff_credit = coin_take ? sum : {1'b0, credit};
        remainder  = credit - PRICE_C;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= ST_COLLECT;
            credit      <= '0;
            change_amt  <= '0;
            vend_count  <= '0;
            coin_reject <= 1'b0;
        end else begin
            coin_reject <= coin_bad;
            case (state)
                ST_COLLECT: begin
                    // Cancel takes priority over vending, even when the price is reached.
                    if (cancel && (eff_credit != '0)) begin
                        credit     <= eff_credit[CREDIT_W-1:0];
                        change_amt <= eff_credit[CREDIT_W-1:0];
                        state      <= ST_CHANGE;
                    end else if (coin_take) begin
                        credit <= sum[CREDIT_W-1:0];
                        if (sum >= PRICE_W) begin
                            state <= ST_VEND;
                        end
                    end
                end
                ST_VEND: begin
                    credit     <= remainder;
                    vend_count <= vend_count + 1'b1;
                    if (remainder != '0) begin
                        change_amt <= remainder;
                        state      <= ST_CHANGE;
                    end else begin
                        state <= ST_COLLECT;
                    end
                end
                ST_CHANGE: begin
                    if (change_ready) begin
                        credit     <= '0;
                        change_amt <= '0;
                        state      <= ST_COLLECT;
                    end
                end
                default: begin
                    state <= ST_COLLECT;
                end
            endcase
        end
    end

endmodule
